// File: rtl/letter_pkg.sv
// -----------------------------------------------------------------------------
// letter_pkg
// Shared definitions for the letter scroller.
//   - 4-bit letter codes in the encoding used by the downstream 7-seg decoder
//   - AN_OFF: anode pattern with every digit dark (anodes are active-low)
//   - state_e: scroller control states
// -----------------------------------------------------------------------------
package letter_pkg;

   localparam logic [3:0] L_A = 4'd0;
   localparam logic [3:0] L_B = 4'd1;
   localparam logic [3:0] L_C = 4'd2;
   localparam logic [3:0] L_D = 4'd3;
   localparam logic [3:0] L_E = 4'd4;
   localparam logic [3:0] L_F = 4'd5;
   localparam logic [3:0] L_G = 4'd6;
   localparam logic [3:0] L_H = 4'd7;
   localparam logic [3:0] L_I = 4'd8;
   localparam logic [3:0] L_L = 4'd9;
   localparam logic [3:0] L_N = 4'd10;
   localparam logic [3:0] L_O = 4'd11;
   localparam logic [3:0] L_P = 4'd12;
   localparam logic [3:0] L_R = 4'd13;
   localparam logic [3:0] L_U = 4'd14;
   localparam logic [3:0] L_Y = 4'd15;

   localparam logic [3:0] AN_OFF = 4'b1111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

endpackage

// File: rtl/tick_div.sv
// -----------------------------------------------------------------------------
// tick_div
// Free-running prescaler that emits a single-cycle tick every DIV enabled
// cycles. The count holds while en=0 and returns to zero on clr or rst.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   en   in  count enable
//   clr  in  synchronous clear (wins over en)
//   tick out 1 during the enabled cycle in which the count reaches DIV-1
// -----------------------------------------------------------------------------
module tick_div #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count and terminal-count tick
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q == TERM) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/letter_scroll_mux.sv
// -----------------------------------------------------------------------------
// letter_scroll_mux
// Holds a message of letter codes, scrolls it right-to-left across a 4-digit
// display (message followed by 4 blank positions) and time-multiplexes the
// anodes. Feeds one letter code per refresh slot to the 7-seg decoder.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en/addr/data    message buffer write (IDLE only, addr>=MSG_MAX ignored)
//   len_we/len_in      message length load (IDLE only, clamped to MSG_MAX)
//   start/pause/stop   control pulses; stop has priority
//   d                  letter code for the active digit
//   an                 active-low anodes, an[3] = leftmost digit
//   blank              active digit shows nothing
//   busy               1 in RUN or PAUSE
//   wrap               1-cycle pulse as the scroll offset returns to 0
// -----------------------------------------------------------------------------
module letter_scroll_mux
   import letter_pkg::*;
#(
   parameter int MSG_MAX     = 16,
   parameter int REFRESH_DIV = 100_000,
   parameter int SCROLL_DIV  = 50_000_000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [$clog2(MSG_MAX)-1:0]   wr_addr,
   input  logic [3:0]                   wr_data,
   input  logic                         len_we,
   input  logic [$clog2(MSG_MAX+1)-1:0] len_in,
   input  logic                         start,
   input  logic                         pause,
   input  logic                         stop,
   output logic [3:0]                   d,
   output logic [3:0]                   an,
   output logic                         blank,
   output logic                         busy,
   output logic                         wrap
);

   localparam int AW = $clog2(MSG_MAX);
   localparam int LW = $clog2(MSG_MAX + 1);
   localparam int OW = $clog2(MSG_MAX + 4);

   localparam logic [LW-1:0] LEN_MAX  = LW'(MSG_MAX);
   localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(MSG_MAX);

   state_e        state_q, state_d;
   logic [LW-1:0] len_q, len_d;
   logic [OW-1:0] offset_q, offset_d;
   logic [1:0]    dsel_q, dsel_d;
   logic          wrap_q, wrap_d;
   logic [3:0]    d_q, d_d;
   logic [3:0]    an_q, an_d;
   logic          blank_q, blank_d;
   logic [3:0]    msg_q [MSG_MAX];

   logic          is_idle;
   logic          div_clr;
   logic          refresh_tick;
   logic          scroll_tick;
   logic [OW-1:0] seq_len;
   logic [1:0]    digit;
   logic [OW:0]   pos_sum;
   logic [OW-1:0] pos;
   logic          pos_blank;
   logic [3:0]    rd_data;

   assign is_idle = (state_q == IDLE);
   // Leaving IDLE always starts both prescalers from zero.
   assign div_clr = stop | is_idle;
   // Virtual sequence is the message followed by four blank positions.
   assign seq_len = OW'(len_q) + OW'(4);

   tick_div #(.DIV(REFRESH_DIV)) u_refresh_div (
      .clk  (clk),
      .rst  (rst),
      .en   (!is_idle),
      .clr  (div_clr),
      .tick (refresh_tick)
   );

   tick_div #(.DIV(SCROLL_DIV)) u_scroll_div (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == RUN),
      .clr  (div_clr),
      .tick (scroll_tick)
   );

   // Control FSM next state and length register load
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      if (stop) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = (start && (len_q != '0)) ? RUN : IDLE;
            RUN:     state_d = pause ? PAUSE : RUN;
            PAUSE:   state_d = pause ? RUN : PAUSE;
            default: state_d = IDLE;
         endcase
      end
      if (len_we && is_idle) begin
         len_d = (len_in > LEN_MAX) ? LEN_MAX : len_in;
      end else begin
         len_d = len_q;
      end
   end

   // Scroll offset, digit select and wrap pulse
   always_comb begin
      offset_d = offset_q;
      dsel_d   = dsel_q;
      wrap_d   = 1'b0;
      if (div_clr) begin
         offset_d = '0;
         dsel_d   = '0;
      end else begin
         if (scroll_tick) begin
            if (offset_q == seq_len - OW'(1)) begin
               offset_d = '0;
               wrap_d   = 1'b1;
            end else begin
               offset_d = offset_q + OW'(1);
            end
         end else begin
            offset_d = offset_q;
         end
         dsel_d = refresh_tick ? (dsel_q + 2'd1) : dsel_q;
      end
   end

   // Display lookup: digit i = 3 - dsel, position (offset + i) mod seq_len
   always_comb begin
      digit   = 2'd3 - dsel_q;
      pos_sum = {1'b0, offset_q} + (OW + 1)'(digit);
      // offset + i < 2*seq_len, so a single conditional subtract is the mod.
      if (pos_sum >= {1'b0, seq_len}) begin
         pos = OW'(pos_sum - {1'b0, seq_len});
      end else begin
         pos = OW'(pos_sum);
      end
      pos_blank = (pos >= OW'(len_q));
      rd_data   = msg_q[pos[AW-1:0]];
      if (is_idle) begin
         d_d     = 4'd0;
         an_d    = AN_OFF;
         blank_d = 1'b1;
      end else begin
         an_d    = ~(4'b0001 << dsel_q);
         blank_d = pos_blank;
         d_d     = pos_blank ? 4'd0 : rd_data;
      end
   end

   // Message buffer write port (contents are deliberately not reset)
   always_ff @(posedge clk) begin
      if (wr_en && is_idle && ({1'b0, wr_addr} < ADDR_LIM)) begin
         msg_q[wr_addr] <= wr_data;
      end
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         len_q    <= '0;
         offset_q <= '0;
         dsel_q   <= '0;
         wrap_q   <= 1'b0;
         d_q      <= 4'd0;
         an_q     <= AN_OFF;
         blank_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         offset_q <= offset_d;
         dsel_q   <= dsel_d;
         wrap_q   <= wrap_d;
         d_q      <= d_d;
         an_q     <= an_d;
         blank_q  <= blank_d;
      end
   end

   assign d     = d_q;
   assign an    = an_q;
   assign blank = blank_q;
   assign busy  = !is_idle;
   assign wrap  = wrap_q;

endmodule
